output_port_allocator: RTL and testbench

- Per-output-port allocator for the 4x4 butterfly router with dropping flow control; one instance per output port.
- Watches the top 4 bits (type + current-hop route) of the four input-register phits and drives the port's one-hot mux select and the route-shift enable.
- Grants by round-robin among competing heads and locks the port to the winner until the packet's tail passes. Losing heads are dropped and counted.
- A lock whose owner stays idle for TIMEOUT consecutive cycles is released.

---
 rtl/router_pkg.sv | 25 ++
 rtl/rr_arbiter4.sv | 29 ++
 rtl/output_port_allocator.sv | 139 +++++++++++++
 tb/tb_output_port_allocator.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared phit layout, phit types and small helpers for the butterfly router
package router_pkg;

  localparam int PHIT_W   = 18;
  localparam int TYPE_HI  = 17;
  localparam int TYPE_LO  = 16;
  localparam int ROUTE_HI = 15;
  localparam int ROUTE_LO = 14;

  localparam logic [1:0] PH_IDLE = 2'b00;
  localparam logic [1:0] PH_HEAD = 2'b10;
  localparam logic [1:0] PH_BODY = 2'b11;
  localparam logic [1:0] PH_TAIL = 2'b01;

  typedef logic [1:0] port_t;

  function automatic logic [3:0] onehot4(input port_t idx);
    return 4'b0001 << idx;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - combinational 4-way round-robin arbiter, search starts at i_ptr
module rr_arbiter4
  import router_pkg::*;
(
  input  logic [3:0] i_req,
  input  port_t      i_ptr,
  output logic [3:0] o_grant,
  output port_t      o_idx
);

  port_t idx;
  logic  found;

  always_comb begin
    o_grant = 4'b0000;
    o_idx   = 2'd0;
    found   = 1'b0;
    idx     = 2'd0;
    for (int j = 0; j < 4; j++) begin
      idx = i_ptr + j[1:0];
      if (!found && i_req[idx]) begin
        found   = 1'b1;
        o_grant = onehot4(idx);
        o_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/output_port_allocator.sv
// rtl/output_port_allocator.sv - per-output-port allocator: round-robin grant, packet lock, drops, idle timeout
module output_port_allocator
  import router_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_this_port,
  input  logic [3:0]       i_r0,
  input  logic [3:0]       i_r1,
  input  logic [3:0]       i_r2,
  input  logic [3:0]       i_r3,
  output logic [3:0]       o_select,
  output logic             o_shift,
  output logic             o_busy,
  output logic [3:0]       o_drop,
  output logic [CNT_W-1:0] o_drop_cnt,
  output logic             o_timeout
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t            state_q, state_d;
  port_t             owner_q, owner_d;
  port_t             ptr_q, ptr_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              timeout_q, timeout_d;

  logic [3:0]        phit [4];
  logic [3:0]        req;
  logic [3:0]        grant;
  port_t             grant_idx;
  logic [1:0]        owner_type;
  logic [CNT_W:0]    drop_sum;

  assign phit[0] = i_r0;
  assign phit[1] = i_r1;
  assign phit[2] = i_r2;
  assign phit[3] = i_r3;

  always_comb begin
    req = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      req[k] = (phit[k][3:2] == PH_HEAD) && (phit[k][1:0] == i_this_port);
    end
  end

  assign owner_type = phit[owner_q][3:2];

  rr_arbiter4 u_arb (
    .i_req   (req),
    .i_ptr   (ptr_q),
    .o_grant (grant),
    .o_idx   (grant_idx)
  );

  always_comb begin
    o_select  = 4'b0000;
    o_shift   = 1'b0;
    o_drop    = 4'b0000;
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    to_cnt_d  = to_cnt_q;
    timeout_d = 1'b0;
    if (i_rst_n) begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            o_select = grant;
            o_shift  = 1'b1;
            o_drop   = req & ~grant;
            state_d  = ST_BUSY;
            owner_d  = grant_idx;
            ptr_d    = grant_idx + 2'd1;
            to_cnt_d = '0;
          end
        end
        default: begin
          o_select = onehot4(owner_q);
          o_drop   = req & ~onehot4(owner_q);
          case (owner_type)
            PH_TAIL: begin
              state_d  = ST_IDLE;
              to_cnt_d = '0;
            end
            PH_BODY: to_cnt_d = '0;
            // A fresh head on the owner means its tail was lost: adopt it in place.
            PH_HEAD: begin
              o_shift  = 1'b1;
              to_cnt_d = '0;
            end
            default: begin
              if (TIMEOUT != 0 && to_cnt_q == TO_LAST) begin
                state_d   = ST_IDLE;
                timeout_d = 1'b1;
                to_cnt_d  = '0;
              end else begin
                to_cnt_d = to_cnt_q + 1'b1;
              end
            end
          endcase
        end
      endcase
    end
  end

  assign drop_sum   = {1'b0, drop_cnt_q} + {{(CNT_W-2){1'b0}}, popcount4(o_drop)};
  assign drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= 2'd0;
      ptr_q      <= 2'd0;
      to_cnt_q   <= '0;
      drop_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      to_cnt_q   <= to_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_busy     = (state_q == ST_BUSY);
  assign o_timeout  = timeout_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_output_port_allocator.sv
// tb/tb_output_port_allocator.sv - self-checking bench for output_port_allocator
module tb_output_port_allocator;

  localparam int TIMEOUT = 4;
  localparam int TO_W    = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b10;
  localparam logic [1:0] T_BODY = 2'b11;
  localparam logic [1:0] T_TAIL = 2'b01;
  localparam logic [3:0] I      = 4'b0000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       this_port = 2'd2;
  logic [3:0]       r0 = '0, r1 = '0, r2 = '0, r3 = '0;
  logic [3:0]       o_select;
  logic             o_shift;
  logic             o_busy;
  logic [3:0]       o_drop;
  logic [CNT_W-1:0] o_drop_cnt;
  logic             o_timeout;

  int n_pass = 0;
  int n_total = 0;

  // behavioural model state
  bit m_locked = 0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_idle = 0;
  int m_cnt = 0;
  bit m_to = 0;

  always #5 clk = ~clk;

  output_port_allocator #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W),
    .CNT_W   (CNT_W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_this_port (this_port),
    .i_r0        (r0),
    .i_r1        (r1),
    .i_r2        (r2),
    .i_r3        (r3),
    .o_select    (o_select),
    .o_shift     (o_shift),
    .o_busy      (o_busy),
    .o_drop      (o_drop),
    .o_drop_cnt  (o_drop_cnt),
    .o_timeout   (o_timeout)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, got, exp, $time);
  endtask

  function automatic logic [3:0] ph(input logic [1:0] t, input logic [1:0] rt);
    return {t, rt};
  endfunction

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    @(posedge clk);
    #1;
    r0 = a; r1 = b; r2 = c; r3 = d;
  endtask

  task automatic pulse_reset(input logic [1:0] port);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    this_port = port;
    r0 = I; r1 = I; r2 = I; r3 = I;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] rand_phit(input logic [1:0] port);
    int          sel;
    logic [1:0]  t;
    logic [1:0]  rt;
    sel = $urandom_range(0, 9);
    if (sel < 3) t = T_IDLE;
    else if (sel < 5) t = T_HEAD;
    else if (sel < 8) t = T_BODY;
    else t = T_TAIL;
    rt = ($urandom_range(0, 1) == 0) ? port : 2'($urandom_range(0, 3));
    return {t, rt};
  endfunction

  // Reference model and per-cycle compare, evaluated mid-cycle on stable inputs.
  always @(negedge clk) begin
    int nib [4];
    int req, e_sel, e_shift, e_drop, win, t, pops;
    nib[0] = r0; nib[1] = r1; nib[2] = r2; nib[3] = r3;
    if (!rst_n) begin
      chk("select", o_select, 0);
      chk("shift", o_shift, 0);
      chk("drop", o_drop, 0);
      chk("busy", o_busy, 0);
      chk("drop_cnt", o_drop_cnt, 0);
      chk("timeout", o_timeout, 0);
      m_locked = 0; m_owner = 0; m_ptr = 0; m_idle = 0; m_cnt = 0; m_to = 0;
    end else begin
      req = 0;
      for (int k = 0; k < 4; k++)
        if ((nib[k] >> 2) == 2 && (nib[k] & 3) == this_port) req |= (1 << k);
      e_sel = 0; e_shift = 0; e_drop = 0; win = -1; t = 0;
      if (!m_locked) begin
        for (int j = 0; j < 4; j++)
          if (win < 0 && req[(m_ptr + j) % 4]) win = (m_ptr + j) % 4;
        if (win >= 0) begin
          e_sel = 1 << win;
          e_shift = 1;
          e_drop = req & ~e_sel;
        end
      end else begin
        e_sel = 1 << m_owner;
        e_drop = req & ~e_sel;
        t = nib[m_owner] >> 2;
        e_shift = (t == 2) ? 1 : 0;
      end
      chk("select", o_select, e_sel);
      chk("shift", o_shift, e_shift);
      chk("drop", o_drop, e_drop);
      chk("busy", o_busy, m_locked);
      chk("drop_cnt", o_drop_cnt, m_cnt);
      chk("timeout", o_timeout, m_to);
      pops = 0;
      for (int k = 0; k < 4; k++) pops += (e_drop >> k) & 1;
      m_cnt = (m_cnt + pops > CNT_MAX) ? CNT_MAX : m_cnt + pops;
      m_to = 0;
      if (!m_locked) begin
        if (win >= 0) begin
          m_locked = 1; m_owner = win; m_ptr = (win + 1) % 4; m_idle = 0;
        end
      end else if (t == 1) begin
        m_locked = 0; m_idle = 0;
      end else if (t == 0) begin
        m_idle++;
        if (TIMEOUT != 0 && m_idle == TIMEOUT) begin
          m_locked = 0; m_to = 1; m_idle = 0;
        end
      end else begin
        m_idle = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset holds outputs quiet while inputs toggle
    repeat (3) begin
      drive(ph(T_HEAD, 2), ph(T_HEAD, 2), rand_phit(2), ph(T_BODY, 2));
      #1;
      chk("rst_select", o_select, 0);
      chk("rst_shift", o_shift, 0);
      chk("rst_drop", o_drop, 0);
      chk("rst_drop_cnt", o_drop_cnt, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; r0 = I; r1 = I; r2 = I; r3 = I;
    drive(I, ph(T_HEAD, 2), I, I);
    #1; chk("pkt_head_sel", o_select, 4'b0010); chk("pkt_head_shift", o_shift, 1); chk("pkt_head_busy", o_busy, 0);
    drive(I, ph(T_BODY, 1), I, I);
    #1; chk("pkt_body_sel", o_select, 4'b0010); chk("pkt_body_shift", o_shift, 0); chk("pkt_body_busy", o_busy, 1);
    drive(I, ph(T_TAIL, 0), I, I);
    #1; chk("pkt_tail_sel", o_select, 4'b0010); chk("pkt_tail_busy", o_busy, 1);
    drive(I, I, I, I);
    #1; chk("pkt_after_sel", o_select, 0); chk("pkt_after_busy", o_busy, 0);

    // contention from a fresh pointer
    pulse_reset(2'd0);
    drive(ph(T_HEAD, 0), I, ph(T_HEAD, 0), ph(T_HEAD, 0));
    #1; chk("cont_grant", o_select, 4'b0001); chk("cont_drop", o_drop, 4'b1100);
    drive(ph(T_BODY, 0), I, I, I);
    #1; chk("cont_cnt", o_drop_cnt, 2);
    drive(ph(T_TAIL, 0), I, I, I);
    drive(ph(T_HEAD, 0), I, ph(T_HEAD, 0), I);
    #1; chk("rr_grant", o_select, 4'b0100); chk("rr_drop", o_drop, 4'b0001);
    drive(I, I, ph(T_TAIL, 0), I);
    #1; chk("rr_cnt", o_drop_cnt, 3);

    // drops while another input holds the lock
    drive(I, I, I, ph(T_HEAD, 0));
    #1; chk("own3_sel", o_select, 4'b1000);
    drive(I, ph(T_HEAD, 0), I, ph(T_BODY, 0));
    #1; chk("busy_drop1", o_drop, 4'b0010); chk("busy_sel1", o_select, 4'b1000);
    drive(I, ph(T_HEAD, 0), I, ph(T_TAIL, 0));
    #1; chk("busy_drop2", o_drop, 4'b0010);
    drive(I, ph(T_HEAD, 0), I, I);
    #1; chk("after_tail_sel", o_select, 4'b0010); chk("after_tail_drop", o_drop, 0); chk("after_tail_shift", o_shift, 1);
    drive(I, ph(T_TAIL, 0), I, I);
    #1; chk("busy_cnt", o_drop_cnt, 5);

    // bubbles shorter than the timeout keep the lock
    drive(ph(T_HEAD, 0), I, I, I);
    repeat (3) drive(I, I, I, I);
    drive(ph(T_BODY, 0), I, I, I);
    #1; chk("bubble_busy", o_busy, 1); chk("bubble_sel", o_select, 4'b0001); chk("bubble_to", o_timeout, 0);
    drive(ph(T_TAIL, 0), I, I, I);
    #1; chk("bubble_tail_busy", o_busy, 1);

    // timeout release with a waiting head on another input
    drive(I, I, ph(T_HEAD, 0), I);
    repeat (4) begin
      drive(I, I, I, I);
      #1; chk("to_wait", o_timeout, 0);
    end
    drive(I, I, I, ph(T_HEAD, 0));
    #1; chk("to_pulse", o_timeout, 1); chk("to_busy", o_busy, 0); chk("to_grant", o_select, 4'b1000); chk("to_shift", o_shift, 1);
    drive(I, I, I, ph(T_TAIL, 0));
    #1; chk("to_pulse_end", o_timeout, 0);

    // counter saturation, then asynchronous reset mid-packet
    drive(ph(T_HEAD, 0), I, I, I);
    repeat (7) drive(ph(T_BODY, 0), ph(T_HEAD, 0), ph(T_HEAD, 0), ph(T_HEAD, 0));
    drive(ph(T_BODY, 0), I, I, I);
    #1; chk("sat_cnt", o_drop_cnt, 15); chk("sat_busy", o_busy, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1; chk("async_busy", o_busy, 0); chk("async_sel", o_select, 0); chk("async_cnt", o_drop_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(ph(T_BODY, 0), I, I, I);
    #1; chk("orphan_body_sel", o_select, 0);
    drive(ph(T_TAIL, 0), I, I, I);
    #1; chk("orphan_tail_sel", o_select, 0); chk("orphan_busy", o_busy, 0);

    // randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      if (c % 250 == 0) pulse_reset(2'($urandom_range(0, 3)));
      drive(rand_phit(this_port), rand_phit(this_port), rand_phit(this_port), rand_phit(this_port));
    end
    drive(I, I, I, I);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
